// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, LSB-first, with
// configurable data width, parity and stop bits.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 6_250_000,
  parameter int BAUD_RATE  = 128000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);
  localparam int BitCycles = CLK_FREQ / BAUD_RATE;
  localparam int CW = (BitCycles > 1) ? $clog2(BitCycles) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CntW = AW + 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BitLast = CW'(BitCycles - 1);

  typedef enum logic [2:0] {
    Idle, Start, Data, Parity, Stop
  } state_t;

  state_t state, nextState;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wrPtr, rdPtr;
  logic [DATA_BITS-1:0] shiftReg;
  logic                 parBit;
  logic [CW-1:0]        bitCnt;
  logic [IW-1:0]        bitIdx;
  logic                 bitEnd, lastData, lastStop;
  logic                 push, pop, fifoEmpty;

  assign fifoEmpty = fifo_count == '0;
  assign tx_ready  = fifo_count != CntW'(FIFO_DEPTH);
  assign push      = tx_valid && tx_ready;
  assign bitEnd    = bitCnt == BitLast;
  assign lastData  = bitIdx == IW'(DATA_BITS - 1);
  assign lastStop  = bitIdx == IW'(STOP_BITS - 1);
  assign busy      = (state != Idle) || !fifoEmpty;

  // Head is taken when idle or exactly as the last stop bit ends.
  assign pop = !fifoEmpty &&
               ((state == Idle) ||
                (state == Stop && bitEnd && lastStop));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      fifo_count <= fifo_count + CntW'(push) - CntW'(pop);
      if (tx_valid && !tx_ready) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= tx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= Idle;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      Idle:   if (!fifoEmpty) nextState = Start;
      Start:  if (bitEnd) nextState = Data;
      Data:
        if (bitEnd && lastData)
          nextState = (PARITY != 0) ? Parity : Stop;
      Parity: if (bitEnd) nextState = Stop;
      Stop:
        if (bitEnd && lastStop)
          nextState = fifoEmpty ? Idle : Start;
      default: nextState = Idle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shiftReg <= '0;
      parBit   <= 1'b0;
      bitCnt   <= '0;
      bitIdx   <= '0;
    end else if (pop) begin
      shiftReg <= mem[rdPtr];
      parBit   <= (^mem[rdPtr]) ^ (PARITY == 1);
      bitCnt   <= '0;
      bitIdx   <= '0;
    end else if (state != Idle) begin
      if (bitEnd) begin
        bitCnt <= '0;
        if (state == Data) begin
          shiftReg <= shiftReg >> 1;
          bitIdx   <= lastData ? '0 : bitIdx + IW'(1);
        end else if (state == Stop) begin
          bitIdx <= lastStop ? '0 : bitIdx + IW'(1);
        end
      end else begin
        bitCnt <= bitCnt + CW'(1);
      end
    end
  end

  always_comb begin
    txd = 1'b1;
    unique case (state)
      Start:   txd = 1'b0;
      Data:    txd = shiftReg[0];
      Parity:  txd = parBit;
      default: txd = 1'b1;
    endcase
  end
endmodule
